// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types for the pipeline sequencing controller
package pipes;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } pipe_ctrl_state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - load-use hazard between EX load and ID sources
module hazard_detect (
    input  logic       i_ex_valid,
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_rd,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_use_rs1,
    input  logic       i_id_use_rs2,
    output logic       o_lu
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);

    // x0 is hardwired to zero, so a load targeting it never creates a hazard
    assign o_lu = i_ex_valid && i_ex_memread && (i_ex_rd != 5'd0)
                  && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - per-stage stall/flush sequencing and redirect tracking for the 5-stage core
module pipe_ctrl
    import pipes::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ireq_busy,
    input  logic             ireq_ok,
    input  logic             dreq_busy,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic [63:0]      ex_target,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic             pc_redirect,
    output logic [63:0]      pc_target,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_ctrl_state_t r_state;
    logic [63:0]      r_pend_pc;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_lu;
    stage_ctrl_t      w_ctrl;
    logic             w_pc_redirect;
    logic [63:0]      w_pc_target;

    hazard_detect u_hazard_detect (
        .i_ex_valid   (ex_valid),
        .i_ex_memread (ex_memread),
        .i_ex_rd      (ex_rd),
        .i_id_rs1     (id_rs1),
        .i_id_rs2     (id_rs2),
        .i_id_use_rs1 (id_use_rs1),
        .i_id_use_rs2 (id_use_rs2),
        .o_lu         (w_lu)
    );

    always_comb begin
        w_ctrl        = CTRL_NONE;
        w_pc_redirect = 1'b0;
        w_pc_target   = (r_state == DROP) ? r_pend_pc : ex_target;
        if (reset) begin
            w_ctrl.flush_d = 1'b1;
            w_ctrl.flush_e = 1'b1;
            w_ctrl.flush_w = 1'b1;
            w_pc_target    = 64'd0;
        end else if (dreq_busy) begin
            // memory stall freezes everything; a pending DROP exit waits for it
            w_ctrl.stall_f = 1'b1;
            w_ctrl.stall_d = 1'b1;
            w_ctrl.stall_e = 1'b1;
            w_ctrl.stall_m = 1'b1;
            w_ctrl.flush_w = 1'b1;
        end else if (r_state == RUN) begin
            if (ex_redirect) begin
                w_ctrl.flush_d = 1'b1;
                w_ctrl.flush_e = 1'b1;
                w_ctrl.stall_f = ireq_busy;
                w_pc_redirect  = !ireq_busy;
            end else if (w_lu) begin
                w_ctrl.stall_f = 1'b1;
                w_ctrl.stall_d = 1'b1;
                w_ctrl.flush_e = 1'b1;
            end else if (ireq_busy) begin
                w_ctrl.stall_f = 1'b1;
                w_ctrl.flush_d = 1'b1;
            end
        end else begin
            // the word returned in DROP belongs to the wrong path and is never latched
            w_ctrl.stall_f = 1'b1;
            w_ctrl.flush_d = 1'b1;
            w_pc_redirect  = ireq_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_pend_pc   <= 64'd0;
            r_stall_cnt <= '0;
        end else begin
            if (w_ctrl.stall_f) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (!dreq_busy) begin
                case (r_state)
                    RUN: begin
                        if (ex_redirect && ireq_busy) begin
                            r_pend_pc <= ex_target;
                            r_state   <= DROP;
                        end
                    end
                    DROP: begin
                        if (ex_redirect) begin
                            r_pend_pc <= ex_target;
                        end
                        if (ireq_ok) begin
                            r_state <= RUN;
                        end
                    end
                    default: r_state <= RUN;
                endcase
            end
        end
    end

    assign stall_f     = w_ctrl.stall_f;
    assign stall_d     = w_ctrl.stall_d;
    assign stall_e     = w_ctrl.stall_e;
    assign stall_m     = w_ctrl.stall_m;
    assign flush_d     = w_ctrl.flush_d;
    assign flush_e     = w_ctrl.flush_e;
    assign flush_w     = w_ctrl.flush_w;
    assign pc_redirect = w_pc_redirect;
    assign pc_target   = w_pc_target;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage RV64I core. It issues per-stage stall and flush controls from three sources: instruction/data bus handshake status, load-use hazards against the decoded instruction, and branch/jump redirects resolved in EX. It also tracks redirects that arrive while a fetch is outstanding, so the stale fetch is discarded and the new PC is applied afterwards.

## Interface
Parameters:
- `CNT_W`, 32: width of the stall-cycle performance counter.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `ireq_busy` in 1: fetch request outstanding, no `data_ok` this cycle.
- `ireq_ok` in 1: fetch `data_ok` this cycle.
- `dreq_busy` in 1: MEM-stage load/store outstanding, no `data_ok` this cycle.
- `id_rs1`, `id_rs2` in 5: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1: ID instruction reads rs1/rs2.
- `ex_valid` in 1: EX holds a real instruction.
- `ex_memread` in 1: EX instruction is a load.
- `ex_rd` in 5: EX destination register.
- `ex_redirect` in 1: EX resolved a taken branch, JAL or JALR.
- `ex_target` in 64: redirect PC.
- `stall_f`, `stall_d`, `stall_e`, `stall_m` out 1: hold PC, IF/ID, ID/EX and EX/MEM registers.
- `flush_d`, `flush_e`, `flush_w` out 1: load a bubble into IF/ID, ID/EX and MEM/WB.
- `pc_redirect` out 1: PC register loads `pc_target` this cycle.
- `pc_target` out 64: redirect target.
- `stall_cnt` out `CNT_W`: count of cycles with `stall_f`=1.

## Operation
- States: RUN and DROP. DROP means a redirect is pending and the outstanding fetch must be discarded.
- Load-use hazard `lu` = `ex_valid` & `ex_memread` & `ex_rd`≠0 & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)).
- Priority, highest first:
  1. `dreq_busy`: `stall_f/d/e/m`=1 and `flush_w`=1. No other flush or redirect is issued. State and `pend_pc` are held.
  2. `ex_redirect` in RUN with `ireq_busy`=0: `pc_redirect`=1, `pc_target`=`ex_target`, `flush_d`=1, `flush_e`=1.
  3. `ex_redirect` in RUN with `ireq_busy`=1: latch `pend_pc`←`ex_target`, go to DROP, `flush_d`=1, `flush_e`=1, `stall_f`=1, `pc_redirect`=0.
  4. `lu`: `stall_f`=1, `stall_d`=1, `flush_e`=1.
  5. `ireq_busy` in RUN: `stall_f`=1, `flush_d`=1.
- In DROP, when not under priority 1:
  - `stall_f`=1 and `flush_d`=1 every cycle.
  - When `ireq_ok`=1: `pc_redirect`=1, `pc_target`=`pend_pc`, then go to RUN. The returned word is never written into IF/ID.
  - An `ex_redirect` in DROP overwrites `pend_pc`.
- When `lu` and `ireq_busy` are both true, `stall_d` wins over `flush_d`: IF/ID is held, not bubbled.
- `pc_target` = `ex_target` in RUN and `pend_pc` in DROP.
- `stall_cnt` increments by 1 (wrapping) every cycle `stall_f`=1.

## Timing
- All control outputs are combinational from inputs and state, valid in the same cycle.
- State, `pend_pc` and `stall_cnt` update on the rising edge of `clk`.
- Redirect latency:
  - No fetch in flight: 0 cycles (same-cycle `pc_redirect`).
  - Fetch in flight: `pc_redirect` in the cycle `ireq_ok` arrives.
- Reset (synchronous, any state, including mid-DROP): next state is RUN, `pend_pc`=0, `stall_cnt`=0.
- While `reset`=1: all `stall_*`=0, `flush_d/e/w`=1, `pc_redirect`=0, `pc_target`=0.
- `ireq_ok` in DROP together with `dreq_busy`: the fetch data is still discarded, but the exit from DROP is deferred until `dreq_busy`=0. The fetch unit holds `data_ok` status until the PC advances.

## Structure
- In package `pipes`:
  - `pipe_ctrl_state_t` enum {RUN, DROP}.
  - `stage_ctrl_t` struct carrying the stall/flush bits.
- Sub-module `hazard_detect`: combinational `lu` computation, reused by a future forwarding unit.
- `pipe_ctrl` holds the FSM, `pend_pc`, the priority mux and the counter.

## Test plan
- EX load `ex_rd`=5, ID `id_rs1`=5 with `id_use_rs1`=1 → `stall_f`=`stall_d`=`flush_e`=1 for exactly 1 cycle; ex_rd=0 → no stall.
- `ex_redirect`=1, `ex_target`=0x8000_0040, `ireq_busy`=0 → same cycle `pc_redirect`=1, `pc_target`=0x8000_0040, `flush_d`=`flush_e`=1.
- Redirect to 0x100 with `ireq_busy`=1 for 3 cycles, then `ireq_ok` → DROP for 3 cycles with `flush_d`=1; on `ireq_ok`, `pc_redirect`=1, `pc_target`=0x100; RUN next cycle.
- `dreq_busy`=1 for 4 cycles concurrent with `ex_redirect` → all stalls=1, `flush_w`=1, no `pc_redirect` until `dreq_busy` drops; then redirect issues.
- Reset asserted in DROP with `pend_pc`=0x200 → next cycle RUN, `pend_pc`=0, `stall_cnt`=0; a later `ireq_ok` produces no redirect.
- `stall_cnt` preloaded to 2^32−1 via a stall run → wraps to 0.
